// File: rtl/acca_mul_pipe_if.sv
// rtl/acca_mul_pipe_if.sv - operand/result handshake bundle for acca_mul_pipe
interface acca_mul_pipe_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [3:0]         mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] prod;
  logic [15:0]        op_count;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, prod, op_count
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, prod, op_count
  );
endinterface

// File: rtl/acca_mul_pipe.sv
// rtl/acca_mul_pipe.sv - 3-stage approximate quadrant multiplier with valid/ready
module acca_mul_pipe #(
  parameter int WIDTH    = 8,
  parameter int APX_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  acca_mul_pipe_if.slave  bus
);
  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  localparam logic [H-1:0] APX_M = H'((1 << APX_BITS) - 1);
  localparam logic [H-1:0] KEEP  = ~APX_M;

  logic             en;
  logic             accept;

  logic [WIDTH-1:0] a1_q, b1_q;
  logic [3:0]       mode1_q;
  logic             v1_q;

  logic [WIDTH-1:0] hh_q, hl_q, lh_q, ll_q;
  logic [WIDTH-1:0] hh_d, hl_d, lh_d, ll_d;
  logic             v2_q;

  logic [PW-1:0]    prod_q, prod_d;
  logic             out_valid_q;
  logic [15:0]      op_count_q, op_count_d;

  function automatic logic [WIDTH-1:0] quad(input logic [H-1:0] x,
                                            input logic [H-1:0] y,
                                            input logic         apx);
    logic [H-1:0] xm;
    logic [H-1:0] ym;
    xm = apx ? (x & KEEP) : x;
    ym = apx ? (y & KEEP) : y;
    return {{H{1'b0}}, xm} * {{H{1'b0}}, ym};
  endfunction

  // The whole pipe moves as one; any stalled result freezes every stage.
  assign en     = !out_valid_q || bus.out_ready;
  assign accept = bus.in_valid && en;

  always_comb begin
    hh_d = quad(a1_q[WIDTH-1:H], b1_q[WIDTH-1:H], mode1_q[3]);
    hl_d = quad(a1_q[WIDTH-1:H], b1_q[H-1:0],     mode1_q[2]);
    lh_d = quad(a1_q[H-1:0],     b1_q[WIDTH-1:H], mode1_q[1]);
    ll_d = quad(a1_q[H-1:0],     b1_q[H-1:0],     mode1_q[0]);
  end

  // Sum of the four half-width products never exceeds 2*WIDTH bits.
  always_comb begin
    prod_d = {hh_q, {WIDTH{1'b0}}}
           + {{H{1'b0}}, hl_q, {H{1'b0}}}
           + {{H{1'b0}}, lh_q, {H{1'b0}}}
           + {{WIDTH{1'b0}}, ll_q};
  end

  always_comb begin
    op_count_d = op_count_q;
    if (accept && (op_count_q != 16'hFFFF)) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q        <= '0;
      b1_q        <= '0;
      mode1_q     <= '0;
      v1_q        <= 1'b0;
      hh_q        <= '0;
      hl_q        <= '0;
      lh_q        <= '0;
      ll_q        <= '0;
      v2_q        <= 1'b0;
      prod_q      <= '0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      op_count_q <= op_count_d;
      if (en) begin
        a1_q        <= bus.a;
        b1_q        <= bus.b;
        mode1_q     <= bus.mode;
        v1_q        <= bus.in_valid;
        hh_q        <= hh_d;
        hl_q        <= hl_d;
        lh_q        <= lh_d;
        ll_q        <= ll_d;
        v2_q        <= v1_q;
        out_valid_q <= v2_q;
        if (v2_q) begin
          prod_q <= prod_d;
        end
      end
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.prod      = prod_q;
  assign bus.op_count  = op_count_q;
endmodule

// File: tb/tb_acca_mul_pipe.sv
// tb/tb_acca_mul_pipe.sv - directed and streamed checks of acca_mul_pipe
module tb_acca_mul_pipe;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  acca_mul_pipe_if #(.WIDTH(8))  bus8 ();
  acca_mul_pipe_if #(.WIDTH(16)) bus16 ();

  acca_mul_pipe #(.WIDTH(8), .APX_BITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  acca_mul_pipe #(.WIDTH(16), .APX_BITS(0)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] m);
    logic [3:0] ah, al, bh, bl;
    logic [15:0] hh, hl, lh, ll;
    ah = m[3] ? (a[7:4] & 4'hC) : a[7:4];
    bh = m[3] ? (b[7:4] & 4'hC) : b[7:4];
    hh = 16'(ah) * 16'(bh);
    ah = m[2] ? (a[7:4] & 4'hC) : a[7:4];
    bl = m[2] ? (b[3:0] & 4'hC) : b[3:0];
    hl = 16'(ah) * 16'(bl);
    al = m[1] ? (a[3:0] & 4'hC) : a[3:0];
    bh = m[1] ? (b[7:4] & 4'hC) : b[7:4];
    lh = 16'(al) * 16'(bh);
    al = m[0] ? (a[3:0] & 4'hC) : a[3:0];
    bl = m[0] ? (b[3:0] & 4'hC) : b[3:0];
    ll = 16'(al) * 16'(bl);
    return (hh << 8) + (hl << 4) + (lh << 4) + ll;
  endfunction

  task automatic do_reset();
    bus8.in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.mode = '0; bus8.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.mode = '0; bus16.out_ready = 1'b1;
    tick();
    n_checks++;
    if (bus8.out_valid !== 1'b0 || bus8.prod !== 16'h0 || bus8.op_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b prod=%h cnt=%h expected ov=0 prod=0000 cnt=0000",
               bus8.out_valid, bus8.prod, bus8.op_count);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus8.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", bus8.in_ready);
    end
  endtask

  // One beat, idle pipe: result must surface exactly on the third edge.
  task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic [3:0] m,
                          input logic [15:0] exp, input string name);
    bus8.a = a; bus8.b = b; bus8.mode = m; bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    bus8.mode = ~m;
    n_checks++;
    if (bus8.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_early1: got ov=%b expected 0", name, bus8.out_valid);
    end
    tick();
    n_checks++;
    if (bus8.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_early2: got ov=%b expected 0", name, bus8.out_valid);
    end
    tick();
    n_checks++;
    if (bus8.out_valid !== 1'b1 || bus8.prod !== exp) begin
      n_fail++;
      $display("FAIL %s: got ov=%b prod=%h expected ov=1 prod=%h", name, bus8.out_valid,
               bus8.prod, exp);
    end
    tick();
  endtask

  task automatic test_exact();
    do_reset();
    send_one(8'hFF, 8'hFF, 4'b0000, 16'hFE01, "exact_ff");
    n_checks++;
    if (bus8.op_count !== 16'd1) begin
      n_fail++;
      $display("FAIL exact_count: got %h expected 0001", bus8.op_count);
    end
    n_checks++;
    if (bus8.out_valid !== 1'b0 || bus8.prod !== 16'hFE01) begin
      n_fail++;
      $display("FAIL bubble_hold: got ov=%b prod=%h expected ov=0 prod=fe01",
               bus8.out_valid, bus8.prod);
    end
  endtask

  task automatic test_modes();
    send_one(8'hFF, 8'hFF, 4'b0001, 16'hFDB0, "mode_ll");
    send_one(8'hFF, 8'hFF, 4'b1111, 16'hA290, "mode_all");
    send_one(8'h12, 8'h34, 4'b0000, 16'h03A8, "exact_1234");
  endtask

  task automatic test_back_to_back();
    logic [7:0]  va [3] = '{8'hFF, 8'hFF, 8'h12};
    logic [7:0]  vb [3] = '{8'hFF, 8'hFF, 8'h34};
    logic [3:0]  vm [3] = '{4'b0000, 4'b0001, 4'b0000};
    logic [15:0] ve [3] = '{16'hFE01, 16'hFDB0, 16'h03A8};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus8.a = va[i]; bus8.b = vb[i]; bus8.mode = vm[i]; bus8.in_valid = 1'b1;
      tick();
    end
    bus8.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus8.out_valid !== 1'b1 || bus8.prod !== ve[i]) begin
        n_fail++;
        $display("FAIL b2b_%0d: got ov=%b prod=%h expected ov=1 prod=%h", i,
                 bus8.out_valid, bus8.prod, ve[i]);
      end
      tick();
    end
    n_checks++;
    if (bus8.out_valid !== 1'b0 || bus8.op_count !== 16'd3) begin
      n_fail++;
      $display("FAIL b2b_tail: got ov=%b cnt=%h expected ov=0 cnt=0003",
               bus8.out_valid, bus8.op_count);
    end
  endtask

  task automatic test_stream_backpressure();
    logic [15:0] exp_q[$];
    logic [15:0] held;
    logic [15:0] exp;
    logic        stall_prev;
    int          sent;
    int          rcvd;
    int          cyc;
    do_reset();
    sent = 0; rcvd = 0; stall_prev = 1'b0; held = '0;
    for (cyc = 0; cyc < 300 && rcvd < 10; cyc++) begin
      bus8.out_ready = ($urandom_range(0, 2) != 0);
      if (sent < 10) begin
        bus8.in_valid = ($urandom_range(0, 3) != 0);
        bus8.a = 8'($urandom_range(0, 255));
        bus8.b = 8'($urandom_range(0, 255));
        bus8.mode = 4'($urandom_range(0, 15));
      end else begin
        bus8.in_valid = 1'b0;
      end
      #1;
      n_checks++;
      if (bus8.in_ready !== (!bus8.out_valid || bus8.out_ready)) begin
        n_fail++;
        $display("FAIL stream_in_ready: got %b expected %b", bus8.in_ready,
                 (!bus8.out_valid || bus8.out_ready));
      end
      if (stall_prev) begin
        n_checks++;
        if (bus8.out_valid !== 1'b1 || bus8.prod !== held) begin
          n_fail++;
          $display("FAIL stream_stall_hold: got ov=%b prod=%h expected ov=1 prod=%h",
                   bus8.out_valid, bus8.prod, held);
        end
      end
      if (bus8.out_valid && bus8.out_ready) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_checks++;
        if (bus8.prod !== exp) begin
          n_fail++;
          $display("FAIL stream_result_%0d: got %h expected %h", rcvd, bus8.prod, exp);
        end
        rcvd++;
      end
      if (bus8.in_valid && bus8.in_ready) begin
        exp_q.push_back(model8(bus8.a, bus8.b, bus8.mode));
        sent++;
      end
      stall_prev = bus8.out_valid && !bus8.out_ready;
      held = bus8.prod;
      tick();
    end
    bus8.in_valid = 1'b0;
    bus8.out_ready = 1'b1;
    n_checks++;
    if (rcvd != 10 || bus8.op_count !== 16'd10) begin
      n_fail++;
      $display("FAIL stream_totals: got rcvd=%0d cnt=%0d expected rcvd=10 cnt=10",
               rcvd, bus8.op_count);
    end
    tick();
    tick();
    tick();
    n_checks++;
    if (bus8.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_no_dup: got ov=%b expected 0", bus8.out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus8.mode = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      bus8.a = 8'(8'h20 + i); bus8.b = 8'h11; bus8.in_valid = 1'b1;
      tick();
    end
    bus8.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus8.out_valid !== 1'b0 || bus8.op_count !== 16'd0) begin
      n_fail++;
      $display("FAIL midreset_async: got ov=%b cnt=%h expected ov=0 cnt=0000",
               bus8.out_valid, bus8.op_count);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (bus8.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_stale_%0d: got ov=%b expected 0", i, bus8.out_valid);
      end
    end
    send_one(8'd3, 8'd5, 4'b0000, 16'd15, "post_reset");
  endtask

  task automatic test_saturation();
    do_reset();
    bus8.a = 8'h01; bus8.b = 8'h01; bus8.mode = 4'b0000; bus8.out_ready = 1'b1;
    bus8.in_valid = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      @(posedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (bus8.op_count !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL sat_pre: got %h expected fffe", bus8.op_count);
    end
    tick();
    n_checks++;
    if (bus8.op_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_reach: got %h expected ffff", bus8.op_count);
    end
    tick();
    tick();
    tick();
    n_checks++;
    if (bus8.op_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_hold: got %h expected ffff", bus8.op_count);
    end
    bus8.in_valid = 1'b0;
  endtask

  task automatic test_width16();
    logic [15:0] va [2] = '{16'hFFFF, 16'h1234};
    logic [15:0] vb [2] = '{16'hFFFF, 16'h5678};
    logic [31:0] ve [2] = '{32'hFFFE0001, 32'h06260060};
    for (int i = 0; i < 2; i++) begin
      bus16.a = va[i]; bus16.b = vb[i]; bus16.mode = 4'b1111; bus16.in_valid = 1'b1;
      tick();
      bus16.in_valid = 1'b0;
      tick();
      tick();
      n_checks++;
      if (bus16.out_valid !== 1'b1 || bus16.prod !== ve[i]) begin
        n_fail++;
        $display("FAIL w16_%0d: got ov=%b prod=%h expected ov=1 prod=%h", i,
                 bus16.out_valid, bus16.prod, ve[i]);
      end
      tick();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_exact();
    test_modes();
    test_back_to_back();
    test_stream_backpressure();
    test_reset_midflight();
    test_width16();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
